tick_delay_sequencer: RTL and testbench
=======================================

Name: tick_delay_sequencer

Overview:
- Controller that sequences the shared clock-divider (tick generator) block to produce programmable delays measured in divider ticks.
- Accepts a start/delay request and drives the divider's enable and synchronous reset so that every delay starts from a freshly cleared divider.
- Counts the delivered ticks and reports busy, done and the remaining tick count.
- Sits between software-visible control logic (timers, debouncers, display refresh) and one divider instance.

Parameters:
- BIT_SZ, 16, width of the delay request and the remaining-tick counter.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- sreset_n  input  1  synchronous reset, active-low.
- start  input  1  request pulse or level; sampled only in IDLE.
- delay  input  BIT_SZ  delay length in divider ticks; sampled with start.
- abort  input  1  cancel the delay in progress.
- tick_in  input  1  tick output of the divider.
- div_enable  output  1  drives the divider's enable input.
- div_sreset  output  1  drives the divider's sreset input (active-high).
- busy  output  1  high in ARM and COUNT.
- done  output  1  one-cycle completion pulse.
- remaining  output  BIT_SZ  ticks still to be counted.

Behaviour:
- All outputs are registered.
- Reset (sreset_n=0 at an edge): state=IDLE, remaining=0, and div_enable, div_sreset, busy, done all 0. Reset has priority over every other input, in every state.
- States: IDLE, ARM, COUNT, DONE.
- IDLE:
  - div_enable=0, busy=0.
  - start=1, delay>0, abort=0: latch remaining=delay and go to ARM.
  - start=1, delay=0, abort=0: go directly to DONE; the divider is untouched.
  - abort=1 overrides start: stay in IDLE.
- ARM (exactly 1 cycle):
  - div_sreset=1, div_enable=0, busy=1; then go to COUNT.
  - abort=1: go to IDLE with remaining=0.
- COUNT:
  - div_enable=1, div_sreset=0, busy=1.
  - The divider's tick output holds its previous value while disabled, so tick_in is ignored in the first COUNT cycle. A one-bit "first" flag, set on entry, provides this qualification.
  - On each qualified tick_in=1: if remaining==1, set remaining=0 and go to DONE; otherwise decrement remaining.
  - abort=1 takes priority over a simultaneous tick: go to IDLE, remaining=0, no done pulse.
- DONE (1 cycle):
  - done=1, busy=0, div_enable=0.
  - Then go to IDLE. start is ignored during DONE.
- start while busy is ignored; delay changes while busy have no effect.
- Arithmetic: remaining is unsigned BIT_SZ.
  - Maximum delay is 2^BIT_SZ-1 ticks.
  - remaining never decrements below 0 and never wraps.
- Latency, with the divider at modulo M and start sampled at edge 0:
  - ARM at edge 1, COUNT from edge 2.
  - The k-th qualified tick is seen at edge 2+k*M.
  - done=1 in the cycle after edge 3+D*M (D = delay).
  - delay=0: done=1 after edge 1.
- div_enable and div_sreset are never both 1.

Test Plan:
- Reset: hold sreset_n=0 for 3 cycles with start=1 and tick_in toggling -> IDLE; all outputs 0; no done pulse.
- Nominal, real divider with M=4: delay=3, start pulse at edge 0 -> busy=1 at edges 1..14; div_sreset=1 only in ARM; remaining reads 3,2,1,0; done=1 for exactly one cycle after edge 15; div_enable=0 afterwards.
- Stale tick: force tick_in=1 before start, delay=2, M=4 -> the first COUNT cycle is not counted; done still arrives after edge 11.
- Zero and maximum delay:
  - delay=0 -> done after edge 1; div_enable and div_sreset stay 0 throughout.
  - delay=16'hFFFF with a forced tick_in every cycle -> done after exactly 65535 qualified ticks.
- Abort: delay=5 with abort at remaining=2, coincident with tick_in=1 -> IDLE next cycle; remaining=0; done never asserted. Abort in ARM likewise returns to IDLE.
- Ignored requests and mid-run reset:
  - start with delay=9 during COUNT -> remaining sequence unchanged.
  - start during DONE -> ignored.
  - sreset_n=0 mid-COUNT -> all outputs 0 next cycle.
  - A subsequent start -> behaves as a fresh run.

Source files
------------

// File: rtl/tick_delay_sequencer.sv
// Sequences a shared clock divider to produce programmable delays counted in divider ticks.
// The divider is cleared for one cycle before every delay so each run starts from a known phase.
module tick_delay_sequencer #(
    parameter int BIT_SZ = 16
) (
    input  logic              clock,
    input  logic              sreset_n,
    input  logic              start,
    input  logic [BIT_SZ-1:0] delay,
    input  logic              abort,
    input  logic              tick_in,
    output logic              div_enable,
    output logic              div_sreset,
    output logic              busy,
    output logic              done,
    output logic [BIT_SZ-1:0] remaining
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_COUNT,
        S_DONE
    } state_t;

    localparam logic [BIT_SZ-1:0] ONE_TICK = BIT_SZ'(1);

    state_t            state_q, state_d;
    logic [BIT_SZ-1:0] remaining_q, remaining_d;
    logic              first_q, first_d;
    logic              div_enable_q, div_enable_d;
    logic              div_sreset_q, div_sreset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick_qual;

    // The divider's tick output still holds its pre-reset value during the first COUNT cycle.
    assign tick_qual = tick_in && !first_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!sreset_n) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            first_q      <= 1'b0;
            div_enable_q <= 1'b0;
            div_sreset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            first_q      <= first_d;
            div_enable_q <= div_enable_d;
            div_sreset_q <= div_sreset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        first_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (delay != '0) begin
                        remaining_d = delay;
                        state_d     = S_ARM;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ARM: begin
                if (abort) begin
                    remaining_d = '0;
                    state_d     = S_IDLE;
                end else begin
                    first_d = 1'b1;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (abort) begin
                    remaining_d = '0;
                    state_d     = S_IDLE;
                end else if (tick_qual) begin
                    if (remaining_q <= ONE_TICK) begin
                        remaining_d = '0;
                        state_d     = S_DONE;
                    end else begin
                        remaining_d = remaining_q - ONE_TICK;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output registers follow the current state, so each output lags its state by one edge.
    always_comb begin
        div_enable_d = 1'b0;
        div_sreset_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        unique case (state_q)
            S_IDLE: ;
            S_ARM: begin
                div_sreset_d = 1'b1;
                busy_d       = 1'b1;
            end
            S_COUNT: begin
                div_enable_d = 1'b1;
                busy_d       = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign div_enable = div_enable_q;
    assign div_sreset = div_sreset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign remaining  = remaining_q;

endmodule

// File: tb/tb_tick_delay_sequencer.sv
// Bench for tick_delay_sequencer: a modulo-M divider model feeds tick_in, and a scoreboard
// holds the expected done cycle of each request while a monitor compares every done pulse.
module tb_tick_delay_sequencer;

    logic        clock;
    logic        sreset_n;
    logic        start;
    logic [15:0] delay;
    logic        abort;
    logic        tick_in;
    logic        div_enable;
    logic        div_sreset;
    logic        busy;
    logic        done;
    logic [15:0] remaining;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_q[$];

    // Divider model: registered tick, holds its value while disabled, cleared by sreset.
    int   div_m      = 4;
    int   div_cnt_q  = 0;
    logic div_tick_q = 1'b0;
    logic force_tick = 1'b0;

    assign tick_in = force_tick ? 1'b1 : div_tick_q;

    tick_delay_sequencer #(.BIT_SZ(16)) dut (
        .clock      (clock),
        .sreset_n   (sreset_n),
        .start      (start),
        .delay      (delay),
        .abort      (abort),
        .tick_in    (tick_in),
        .div_enable (div_enable),
        .div_sreset (div_sreset),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        int nxt;
        if (div_sreset) begin
            div_cnt_q  <= 0;
            div_tick_q <= 1'b0;
        end else if (div_enable) begin
            nxt = (div_cnt_q == div_m - 1) ? 0 : div_cnt_q + 1;
            div_cnt_q  <= nxt;
            div_tick_q <= (nxt == div_m - 1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        check("enable_sreset_exclusive", {31'd0, div_enable & div_sreset}, 32'd0);
        if (done === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_done", {31'd0, done}, 32'd0);
            else                   check("done_cycle", cyc, exp_q.pop_front());
        end
    end

    // Called at a falling edge: start is sampled at the next rising edge (edge e0).
    task automatic issue(input logic [15:0] d, input int m, input bit expect_done, output int e0);
        start = 1'b1;
        delay = d;
        e0    = cyc + 1;
        if (expect_done) exp_q.push_back((d == 16'd0) ? e0 + 1 : e0 + 3 + int'(d) * m);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    initial begin
        int e0;
        sreset_n = 1'b0;
        start    = 1'b1;
        delay    = 16'd5;
        abort    = 1'b0;

        // Reset dominates a live start and a toggling tick.
        repeat (3) begin
            @(negedge clock);
            force_tick = ~force_tick;
            check("reset_outputs", {12'd0, div_enable, div_sreset, busy, done, remaining}, 32'd0);
        end
        sreset_n   = 1'b1;
        start      = 1'b0;
        force_tick = 1'b0;
        repeat (3) @(negedge clock);

        // Nominal run, D=3, M=4: done after edge e0+15.
        div_m = 4;
        issue(16'd3, 4, 1'b1, e0);
        for (int k = 1; k <= 17; k++) begin
            wait_until(e0 + k);
            check("nom_busy",   {31'd0, busy},       {31'd0, (k >= 1 && k <= 14)});
            check("nom_sreset", {31'd0, div_sreset}, {31'd0, (k == 1)});
            check("nom_enable", {31'd0, div_enable}, {31'd0, (k >= 2 && k <= 14)});
            check("nom_remaining", {16'd0, remaining},
                  (k < 6) ? 32'd3 : (k < 10) ? 32'd2 : (k < 14) ? 32'd1 : 32'd0);
        end
        wait_until(e0 + 20);

        // Stale tick held high through ARM and the first COUNT cycle, D=2, M=4.
        force_tick = 1'b1;
        issue(16'd2, 4, 1'b1, e0);
        wait_until(e0 + 2);
        force_tick = 1'b0;
        check("stale_remaining", {16'd0, remaining}, 32'd2);
        wait_until(e0 + 14);

        // Zero delay: done after edge e0+1, divider never touched.
        issue(16'd0, 4, 1'b1, e0);
        for (int k = 1; k <= 3; k++) begin
            wait_until(e0 + k);
            check("zero_enable", {31'd0, div_enable}, 32'd0);
            check("zero_sreset", {31'd0, div_sreset}, 32'd0);
            check("zero_busy",   {31'd0, busy},       32'd0);
        end
        wait_until(e0 + 5);

        // Abort coincident with a qualified tick at remaining=2, D=5, M=4.
        issue(16'd5, 4, 1'b0, e0);
        wait_until(e0 + 17);
        check("abort_pre_remaining", {16'd0, remaining}, 32'd2);
        check("abort_pre_tick", {31'd0, tick_in}, 32'd1);
        abort = 1'b1;
        wait_until(e0 + 18);
        abort = 1'b0;
        check("abort_remaining", {16'd0, remaining}, 32'd0);
        wait_until(e0 + 19);
        check("abort_busy",   {31'd0, busy},       32'd0);
        check("abort_enable", {31'd0, div_enable}, 32'd0);
        wait_until(e0 + 30);

        // Abort while in ARM.
        issue(16'd4, 4, 1'b0, e0);
        abort = 1'b1;
        wait_until(e0 + 1);
        abort = 1'b0;
        check("arm_abort_remaining", {16'd0, remaining}, 32'd0);
        wait_until(e0 + 2);
        check("arm_abort_busy",   {31'd0, busy},       32'd0);
        check("arm_abort_sreset", {31'd0, div_sreset}, 32'd0);
        wait_until(e0 + 6);
        check("arm_abort_enable", {31'd0, div_enable}, 32'd0);
        wait_until(e0 + 10);

        // Start during COUNT and during DONE are both ignored.
        issue(16'd3, 4, 1'b1, e0);
        wait_until(e0 + 4);
        start = 1'b1;
        delay = 16'd9;
        wait_until(e0 + 7);
        start = 1'b0;
        check("busy_start_rem_a", {16'd0, remaining}, 32'd2);
        wait_until(e0 + 11);
        check("busy_start_rem_b", {16'd0, remaining}, 32'd1);
        wait_until(e0 + 14);
        start = 1'b1;
        wait_until(e0 + 15);
        start = 1'b0;
        wait_until(e0 + 16);
        check("done_start_busy",      {31'd0, busy},      32'd0);
        check("done_start_remaining", {16'd0, remaining}, 32'd0);
        wait_until(e0 + 22);

        // Reset in the middle of COUNT, then a fresh run.
        issue(16'd3, 4, 1'b0, e0);
        wait_until(e0 + 7);
        sreset_n = 1'b0;
        wait_until(e0 + 8);
        sreset_n = 1'b1;
        check("midrst_outputs", {12'd0, div_enable, div_sreset, busy, done, remaining}, 32'd0);
        wait_until(e0 + 10);
        issue(16'd2, 4, 1'b1, e0);
        check("fresh_remaining", {16'd0, remaining}, 32'd2);
        wait_until(e0 + 14);

        // Maximum delay with a tick forced on every cycle.
        force_tick = 1'b1;
        issue(16'hFFFF, 1, 1'b1, e0);
        wait_until(e0 + 2);
        check("max_rem_first", {16'd0, remaining}, 32'h0000_FFFF);
        wait_until(e0 + 3);
        check("max_rem_second", {16'd0, remaining}, 32'h0000_FFFE);
        wait_until(e0 + 65536);
        check("max_rem_last", {16'd0, remaining}, 32'd1);
        wait_until(e0 + 65537);
        check("max_rem_zero", {16'd0, remaining}, 32'd0);
        wait_until(e0 + 65540);
        force_tick = 1'b0;
        check("max_busy_after", {31'd0, busy}, 32'd0);
        wait_until(e0 + 65545);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
